dcache_assoc_datapath: RTL

//  N-way set-associative successor to the direct-mapped dcache datapath: tag/valid/dirty/data

---
 rtl/dcache_assoc_datapath.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_assoc_datapath.sv
// N-way set-associative dcache datapath: tag/valid/dirty/data storage, parallel lookup,
// per-set round-robin victim choice, byte-lane store merge and word-serial L2 fill/evict.
package dcache_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD} memory_operation_size_e;
  typedef enum logic {LOAD, STORE} memory_operation_e;
endpackage

module dcache_assoc_datapath
  import dcache_pkg::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int OFS_SIZE  = 5,
  parameter int SET_SIZE  = 5,
  parameter int TAG_SIZE  = 22,
  parameter int NUM_SETS  = 32,
  parameter int NUM_WAYS  = 2,
  parameter int XLEN      = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [OFS_SIZE-1:0]    req_ofs_i,
  input  logic [SET_SIZE-1:0]    req_set_i,
  input  logic [TAG_SIZE-1:0]    req_tag_i,
  input  memory_operation_size_e req_size_i,
  input  memory_operation_e      req_type_i,
  input  logic                   req_valid_i,
  input  logic [XLEN-1:0]        req_data_i,
  output logic [XLEN-1:0]        rsp_data_o,
  input  logic                   flush_mode_i,
  input  logic                   load_mode_i,
  input  logic                   l2_word_ack_i,
  input  logic [XLEN-1:0]        fill_data_i,
  output logic [XLEN-1:0]        evict_data_o,
  input  logic                   clear_selected_dirty_bit_i,
  input  logic                   finish_new_line_install_i,
  output logic                   hit_o,
  output logic                   clean_miss_o,
  output logic                   dirty_miss_o,
  output logic                   line_done_o,
  output logic [XLEN-1:0]        l2_address_o
);

  localparam int BYTES_PER_WORD = XLEN / 8;
  localparam int WORDS_PER_LINE = LINE_SIZE / BYTES_PER_WORD;
  localparam int BYTE_SEL       = $clog2(BYTES_PER_WORD);
  localparam int WSEL           = OFS_SIZE - BYTE_SEL;
  localparam int WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [TAG_SIZE-1:0]          tag_q    [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]              data_q   [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [NUM_WAYS-1:0]          valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0]          dirty_q  [NUM_SETS];
  logic [WAY_W-1:0]             rr_ptr_q [NUM_SETS];

  logic [WSEL-1:0]              counter_q, counter_d;
  logic [WAY_W-1:0]             victim_q;
  logic [TAG_SIZE+SET_SIZE-1:0] block_q;
  logic                         lock_q;

  logic [NUM_WAYS-1:0] hit_way;
  logic [WAY_W-1:0]    hit_idx;
  logic [WAY_W-1:0]    victim;
  logic                victim_found;
  logic                any_hit;
  logic                victim_valid, victim_dirty;
  logic                miss;
  logic                store_hit;
  logic                word_ack;
  logic [WAY_W-1:0]    rr_next;
  logic [WSEL-1:0]     word_sel;
  logic [BYTE_SEL-1:0] byte_ofs;
  logic [XLEN-1:0]     hit_word;
  logic [XLEN-1:0]     merged;

  assign word_sel = req_ofs_i[OFS_SIZE-1:BYTE_SEL];
  assign byte_ofs = req_ofs_i[BYTE_SEL-1:0];

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      hit_way[w] = valid_q[req_set_i][w] && (tag_q[req_set_i][w] == req_tag_i);
  end

  always_comb begin
    hit_idx = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (hit_way[w]) hit_idx = WAY_W'(w);
  end

  // Fill empty ways first; round-robin only once the set is full.
  always_comb begin
    victim       = rr_ptr_q[req_set_i];
    victim_found = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_q[req_set_i][w] && !victim_found) begin
        victim       = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  assign any_hit      = |hit_way;
  assign victim_valid = valid_q[req_set_i][victim];
  assign victim_dirty = dirty_q[req_set_i][victim];

  assign hit_o        = req_valid_i && any_hit;
  assign dirty_miss_o = req_valid_i && !any_hit && victim_valid && victim_dirty;
  assign clean_miss_o = req_valid_i && !any_hit && !dirty_miss_o;
  assign miss         = clean_miss_o || dirty_miss_o;

  assign store_hit = hit_o && !load_mode_i && !flush_mode_i && (req_type_i == STORE);
  assign word_ack  = l2_word_ack_i && (load_mode_i || flush_mode_i);
  assign rr_next   = WAY_W'((int'(victim_q) + 1) % NUM_WAYS);

  assign hit_word     = data_q[req_set_i][hit_idx][word_sel];
  assign rsp_data_o   = hit_o ? hit_word : '0;
  assign evict_data_o = data_q[req_set_i][victim_q][counter_q];
  assign l2_address_o = {block_q, counter_q, {BYTE_SEL{1'b0}}};
  assign line_done_o  = word_ack && !reset_i && (counter_q == WSEL'(WORDS_PER_LINE - 1));

  assign counter_d = word_ack ? counter_q + 1'b1 : counter_q;

  // HALF stores ignore ofs[0]: both lanes of the aligned halfword are written.
  always_comb begin
    merged = hit_word;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      case (req_size_i)
        BYTE: if (BYTE_SEL'(b) == byte_ofs)
                merged[8*b +: 8] = req_data_i[7:0];
        HALF: if ((BYTE_SEL'(b) >> 1) == (byte_ofs >> 1))
                merged[8*b +: 8] = req_data_i[8*(b%2) +: 8];
        default: merged[8*b +: 8] = req_data_i[8*b +: 8];
      endcase
    end
  end

  // Later assignments win: install > clear_dirty > store-hit dirty set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        dirty_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
      counter_q <= '0;
      victim_q  <= '0;
      block_q   <= '0;
      lock_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      if (miss && !lock_q) begin
        victim_q <= victim;
        block_q  <= {dirty_miss_o ? tag_q[req_set_i][victim] : req_tag_i, req_set_i};
        lock_q   <= 1'b1;
      end
      if (clear_selected_dirty_bit_i)
        block_q <= {req_tag_i, req_set_i};
      if (store_hit)
        dirty_q[req_set_i][hit_idx] <= 1'b1;
      if (clear_selected_dirty_bit_i)
        dirty_q[req_set_i][victim_q] <= 1'b0;
      if (finish_new_line_install_i) begin
        valid_q[req_set_i][victim_q] <= 1'b1;
        dirty_q[req_set_i][victim_q] <= 1'b0;
        rr_ptr_q[req_set_i]          <= rr_next;
        lock_q                       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (finish_new_line_install_i)
        tag_q[req_set_i][victim_q] <= req_tag_i;
      if (load_mode_i && l2_word_ack_i)
        data_q[req_set_i][victim_q][counter_q] <= fill_data_i;
      else if (store_hit)
        data_q[req_set_i][hit_idx][word_sel] <= merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && req_valid_i)
      assert ($onehot0(hit_way));
  end

endmodule
